// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// proc_pkg : shared owner encoding, tag entry and legality helpers for the
//            IF/MEM memory port arbiter.                            Rev 1.0
// ============================================================================
package proc_pkg;

    localparam int OWNER_W   = 1;
    localparam int VALID_W   = 1;
    localparam int DISCARD_W = 1;

    typedef logic [OWNER_W-1:0] owner_t;

    localparam owner_t OWN_IF = 1'b0;
    localparam owner_t OWN_DM = 1'b1;

    typedef struct packed {
        logic [VALID_W-1:0]   valid;
        owner_t               owner;
        logic [DISCARD_W-1:0] discard;
    } tag_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } req_state_e;

    localparam int MEM_LAT_MIN    = 1;
    localparam int MEM_LAT_MAX    = 4;
    localparam int STARVE_MIN     = 1;
    localparam int STARVE_MAX_LIM = 15;

    // Out-of-range settings fall back to the nearest legal value.
    function automatic int legal_mem_lat(input int lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

    function automatic int legal_starve(input int n);
        if (n < STARVE_MIN)     return STARVE_MIN;
        if (n > STARVE_MAX_LIM) return STARVE_MAX_LIM;
        return n;
    endfunction

    function automatic tag_t mark_discard(input tag_t t, input logic set);
        tag_t r;
        r = t;
        r.discard = t.discard | (set & t.valid & (t.owner == OWN_IF));
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : IF-stage, MEM-stage and memory-side signal bundle.
//                                                                   Rev 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req_t;
    logic [ADDR_W-1:0]     if_addr_t;
    logic                  if_flush_t;
    logic [DATA_W-1:0]     if_rdata_t;
    logic                  if_valid_t;
    logic                  if_stall_t;

    logic                  dm_req_t;
    logic                  dm_we_t;
    logic [ADDR_W-1:0]     dm_addr_t;
    logic [DATA_W-1:0]     dm_wdata_t;
    logic [DATA_W/8-1:0]   dm_wstrb_t;
    logic [DATA_W-1:0]     dm_rdata_t;
    logic                  dm_valid_t;
    logic                  dm_stall_t;

    logic                  mem_en_t;
    logic                  mem_we_t;
    logic [ADDR_W-1:0]     mem_addr_t;
    logic [DATA_W-1:0]     mem_wdata_t;
    logic [DATA_W/8-1:0]   mem_wstrb_t;
    logic [DATA_W-1:0]     mem_rdata_t;

    modport slave (
        input  if_req_t, if_addr_t, if_flush_t,
        output if_rdata_t, if_valid_t, if_stall_t,
        input  dm_req_t, dm_we_t, dm_addr_t, dm_wdata_t, dm_wstrb_t,
        output dm_rdata_t, dm_valid_t, dm_stall_t,
        output mem_en_t, mem_we_t, mem_addr_t, mem_wdata_t, mem_wstrb_t,
        input  mem_rdata_t
    );

    modport master (
        output if_req_t, if_addr_t, if_flush_t,
        input  if_rdata_t, if_valid_t, if_stall_t,
        output dm_req_t, dm_we_t, dm_addr_t, dm_wdata_t, dm_wstrb_t,
        input  dm_rdata_t, dm_valid_t, dm_stall_t,
        input  mem_en_t, mem_we_t, mem_addr_t, mem_wdata_t, mem_wstrb_t,
        output mem_rdata_t
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_tag_pipe.sv
`default_nettype none
// ============================================================================
// arb_tag_pipe : DEPTH-stage shift register of in-flight access tags; the
//                head lines up with the memory response slot.       Rev 1.0
// ============================================================================
module arb_tag_pipe
    import proc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    input  wire logic   push_i,
    input  wire owner_t owner_i,
    input  wire logic   disc_set_i,
    output logic        head_valid_o,
    output owner_t      head_owner_o,
    output logic        head_discard_o
);

    // Entries enter one cycle after the grant, so a fetch flush is applied
    // both to the entry being pushed and to entries already in flight.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        tag_t tag_d;
        tag_t tag_q;

        if (k == 0) begin : g_first
            assign tag_d = mark_discard(tag_t'{valid: push_i, owner: owner_i, discard: 1'b0},
                                        disc_set_i);
        end else begin : g_next
            assign tag_d = mark_discard(g_stage[k-1].tag_q, disc_set_i);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) tag_q <= '0;
            else       tag_q <= tag_d;
        end
    end

    tag_t w_head;
    assign w_head         = mark_discard(g_stage[DEPTH-1].tag_q, disc_set_i);
    assign head_valid_o   = w_head.valid;
    assign head_owner_o   = w_head.owner;
    assign head_discard_o = w_head.discard;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one pipelined single-port memory between the IF
//                    and MEM stages with starvation guard and fetch flush.
//                                                                   Rev 1.0
// ============================================================================
module mem_port_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input wire logic          clk_t,
    input wire logic          rst_t,
    mem_port_arbiter_if.slave bus
);

    localparam int         c_PIPE_DEPTH = legal_mem_lat(MEM_LAT);
    localparam logic [3:0] c_STARVE_LIM = 4'(legal_starve(STARVE_MAX));
    localparam int         c_STRB_W     = DATA_W / 8;

    req_state_e            if_st_q, dm_st_q;
    logic [3:0]            starve_q, starve_d;
    logic                  dm_we_q;
    logic                  mem_en_q, mem_we_q;
    owner_t                mem_own_q;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [c_STRB_W-1:0]   mem_wstrb_q;

    logic   w_head_v, w_head_disc;
    owner_t w_head_own;
    logic   w_if_done, w_dm_done, w_if_free, w_dm_free;
    logic   w_if_elig, w_dm_elig, w_if_win, w_dm_win, w_disc_set;

    assign w_disc_set = bus.if_flush_t & (if_st_q == ST_WAIT);

    arb_tag_pipe #(
        .DEPTH (c_PIPE_DEPTH)
    ) u_tag_pipe (
        .clk_i          (clk_t),
        .rst_i          (rst_t),
        .push_i         (mem_en_q),
        .owner_i        (mem_own_q),
        .disc_set_i     (w_disc_set),
        .head_valid_o   (w_head_v),
        .head_owner_o   (w_head_own),
        .head_discard_o (w_head_disc)
    );

    assign w_if_done = w_head_v & (w_head_own == OWN_IF);
    assign w_dm_done = w_head_v & (w_head_own == OWN_DM);

    // A requester completing this cycle may be granted again immediately.
    assign w_if_free = (if_st_q == ST_IDLE) | w_if_done;
    assign w_dm_free = (dm_st_q == ST_IDLE) | w_dm_done;

    assign w_if_elig = bus.if_req_t & ~bus.if_flush_t & w_if_free;
    assign w_dm_elig = bus.dm_req_t & w_dm_free;
    assign w_if_win  = w_if_elig & (~w_dm_elig | (starve_q >= c_STARVE_LIM));
    assign w_dm_win  = w_dm_elig & ~w_if_win;

    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req_t || w_if_win)
            starve_d = '0;
        else if (w_dm_win && w_if_free && (starve_q != 4'hF))
            starve_d = starve_q + 4'd1;
    end

    always_comb begin
        mem_addr_d = '0;
        if (w_dm_win)      mem_addr_d = bus.dm_addr_t;
        else if (w_if_win) mem_addr_d = bus.if_addr_t;
    end

    always_ff @(posedge clk_t) begin
        if (rst_t) begin
            if_st_q     <= ST_IDLE;
            dm_st_q     <= ST_IDLE;
            starve_q    <= '0;
            dm_we_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_own_q   <= OWN_IF;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            if (w_if_win)       if_st_q <= ST_WAIT;
            else if (w_if_done) if_st_q <= ST_IDLE;

            if (w_dm_win) begin
                dm_st_q <= ST_WAIT;
                dm_we_q <= bus.dm_we_t;
            end else if (w_dm_done) begin
                dm_st_q <= ST_IDLE;
            end

            starve_q    <= starve_d;
            mem_en_q    <= w_if_win | w_dm_win;
            mem_we_q    <= w_dm_win & bus.dm_we_t;
            mem_own_q   <= w_dm_win ? OWN_DM : OWN_IF;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= (w_dm_win && bus.dm_we_t) ? bus.dm_wdata_t : '0;
            mem_wstrb_q <= (w_dm_win && bus.dm_we_t) ? bus.dm_wstrb_t : '0;
        end
    end

    assign bus.mem_en_t    = mem_en_q;
    assign bus.mem_we_t    = mem_we_q;
    assign bus.mem_addr_t  = mem_addr_q;
    assign bus.mem_wdata_t = mem_wdata_q;
    assign bus.mem_wstrb_t = mem_wstrb_q;

    assign bus.if_valid_t  = w_if_done & ~w_head_disc;
    assign bus.if_rdata_t  = bus.if_valid_t ? bus.mem_rdata_t : '0;
    assign bus.dm_valid_t  = w_dm_done;
    assign bus.dm_rdata_t  = (w_dm_done && !dm_we_q) ? bus.mem_rdata_t : '0;

    assign bus.if_stall_t  = bus.if_req_t & ~bus.if_valid_t;
    assign bus.dm_stall_t  = bus.dm_req_t & ~bus.dm_valid_t;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed self-checking bench, MEM_LAT=2, STARVE_MAX=4.
//                                                                   Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic clk_t = 1'b0;
    logic rst_t = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_t = ~clk_t;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MEM_LAT    (2),
        .STARVE_MAX (4)
    ) dut (
        .clk_t (clk_t),
        .rst_t (rst_t),
        .bus   (bus)
    );

    // Memory model: word i of the array starts as 0xA0000000 | byte address.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q [0:1];

    always @(posedge clk_t) begin
        if (bus.mem_en_t && bus.mem_we_t) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wstrb_t[b])
                    mem[bus.mem_addr_t[11:2]][8*b +: 8] = bus.mem_wdata_t[8*b +: 8];
        end
        rd_q[0] <= (bus.mem_en_t && !bus.mem_we_t) ? mem[bus.mem_addr_t[11:2]] : 32'hFFFF_FFFF;
        rd_q[1] <= rd_q[0];
    end
    assign bus.mem_rdata_t = rd_q[1];

    task automatic tick();
        @(posedge clk_t);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | (i << 2);
        mem[32'h300 >> 2] = 32'h0;
        bus.if_req_t   = 1'b0;  bus.if_addr_t  = '0;  bus.if_flush_t = 1'b0;
        bus.dm_req_t   = 1'b0;  bus.dm_we_t    = 1'b0; bus.dm_addr_t = '0;
        bus.dm_wdata_t = '0;    bus.dm_wstrb_t = '0;

        // Reset state
        repeat (3) tick();
        #1;
        chk("rst_mem_en",   bus.mem_en_t,   0);
        chk("rst_if_valid", bus.if_valid_t, 0);
        chk("rst_dm_valid", bus.dm_valid_t, 0);
        chk("rst_if_stall", bus.if_stall_t, 0);
        rst_t = 1'b0;
        tick();

        // Lone fetch 0x100: grant A, issue A+1, valid A+3
        tick(); bus.if_req_t = 1'b1; bus.if_addr_t = 32'h100; #1;
        chk("f1_stall_grant", bus.if_stall_t, 1);
        chk("f1_no_en_yet",   bus.mem_en_t,   0);
        tick(); #1;
        chk("f1_mem_en",   bus.mem_en_t,   1);
        chk("f1_mem_addr", bus.mem_addr_t, 32'h100);
        chk("f1_mem_we",   bus.mem_we_t,   0);
        chk("f1_stall",    bus.if_stall_t, 1);
        tick(); #1;
        chk("f1_early_valid", bus.if_valid_t, 0);
        chk("f1_stall2",      bus.if_stall_t, 1);
        tick(); bus.if_req_t = 1'b0; #1;
        chk("f1_valid", bus.if_valid_t, 1);
        chk("f1_rdata", bus.if_rdata_t, 32'hA000_0100);
        tick(); #1;
        chk("f1_valid_pulse", bus.if_valid_t, 0);

        // Starvation: flush holds IF off while 4 loads issue, then IF wins
        tick();
        bus.if_req_t = 1'b1; bus.if_addr_t = 32'h108; bus.if_flush_t = 1'b1;
        bus.dm_req_t = 1'b1; bus.dm_we_t = 1'b0; bus.dm_addr_t = 32'h204;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("sv_dm_issue_en",   bus.mem_en_t,   1);
            chk("sv_dm_issue_addr", bus.mem_addr_t, 32'h204);
            tick();
            tick();
        end
        bus.if_flush_t = 1'b0; #1;
        chk("sv_dm_valid", bus.dm_valid_t, 1);
        chk("sv_dm_rdata", bus.dm_rdata_t, 32'hA000_0204);
        chk("sv_idle_slot", bus.mem_en_t, 0);
        tick(); bus.dm_req_t = 1'b0; #1;
        chk("sv_if_issue_en",   bus.mem_en_t,   1);
        chk("sv_if_issue_addr", bus.mem_addr_t, 32'h108);
        tick();
        tick(); bus.if_req_t = 1'b0; #1;
        chk("sv_if_valid", bus.if_valid_t, 1);
        chk("sv_if_rdata", bus.if_rdata_t, 32'hA000_0108);

        // Both request together: data first (starve counter back at 0)
        tick();
        bus.dm_req_t = 1'b1; bus.dm_we_t = 1'b0; bus.dm_addr_t = 32'h200;
        bus.if_req_t = 1'b1; bus.if_addr_t = 32'h104;
        tick(); #1;
        chk("b_dm_first", bus.mem_addr_t, 32'h200);
        chk("b_dm_stall", bus.dm_stall_t, 1);
        chk("b_if_stall", bus.if_stall_t, 1);
        tick(); #1;
        chk("b_if_en",   bus.mem_en_t,   1);
        chk("b_if_addr", bus.mem_addr_t, 32'h104);
        tick(); bus.dm_req_t = 1'b0; #1;
        chk("b_dm_valid", bus.dm_valid_t, 1);
        chk("b_dm_rdata", bus.dm_rdata_t, 32'hA000_0200);
        chk("b_if_not_yet", bus.if_valid_t, 0);
        tick(); bus.if_req_t = 1'b0; #1;
        chk("b_if_valid", bus.if_valid_t, 1);
        chk("b_if_rdata", bus.if_rdata_t, 32'hA000_0104);

        // Partial store then read-back
        tick();
        bus.dm_req_t = 1'b1; bus.dm_we_t = 1'b1; bus.dm_addr_t = 32'h300;
        bus.dm_wdata_t = 32'hDEAD_BEEF; bus.dm_wstrb_t = 4'b0011;
        tick(); #1;
        chk("st_we",    bus.mem_we_t,    1);
        chk("st_wstrb", bus.mem_wstrb_t, 4'b0011);
        chk("st_wdata", bus.mem_wdata_t, 32'hDEAD_BEEF);
        tick();
        tick(); bus.dm_req_t = 1'b0; #1;
        chk("st_valid", bus.dm_valid_t, 1);
        chk("st_rdata", bus.dm_rdata_t, 0);
        tick();
        bus.dm_req_t = 1'b1; bus.dm_we_t = 1'b0;
        tick(); #1;
        chk("ld_we",    bus.mem_we_t,    0);
        chk("ld_wstrb", bus.mem_wstrb_t, 0);
        tick();
        tick(); bus.dm_req_t = 1'b0; #1;
        chk("ld_valid", bus.dm_valid_t, 1);
        chk("ld_rdata", bus.dm_rdata_t, 32'h0000_BEEF);

        // Flush in WAIT: old fetch discarded, 0x400 issues back-to-back
        tick(); bus.if_req_t = 1'b1; bus.if_addr_t = 32'h10C;
        tick(); bus.if_flush_t = 1'b1; bus.if_addr_t = 32'h400; #1;
        chk("fl_issue_addr", bus.mem_addr_t, 32'h10C);
        tick(); bus.if_flush_t = 1'b0;
        tick(); #1;
        chk("fl_discard", bus.if_valid_t, 0);
        chk("fl_stall",   bus.if_stall_t, 1);
        tick(); #1;
        chk("fl_new_en",   bus.mem_en_t,   1);
        chk("fl_new_addr", bus.mem_addr_t, 32'h400);
        tick();
        tick(); bus.if_req_t = 1'b0; #1;
        chk("fl_new_valid", bus.if_valid_t, 1);
        chk("fl_new_rdata", bus.if_rdata_t, 32'hA000_0400);

        // Flush in the grant cycle cancels the issue
        tick(); bus.if_req_t = 1'b1; bus.if_addr_t = 32'h110; bus.if_flush_t = 1'b1;
        tick(); bus.if_flush_t = 1'b0; #1;
        chk("fc_cancelled", bus.mem_en_t, 0);
        tick(); #1;
        chk("fc_issue_addr", bus.mem_addr_t, 32'h110);
        tick();
        tick(); bus.if_req_t = 1'b0; #1;
        chk("fc_valid", bus.if_valid_t, 1);
        chk("fc_rdata", bus.if_rdata_t, 32'hA000_0110);

        // Reset with a load in flight: stale response must be dropped
        tick(); bus.dm_req_t = 1'b1; bus.dm_we_t = 1'b0; bus.dm_addr_t = 32'h200;
        tick(); #1;
        chk("rs_issue", bus.mem_en_t, 1);
        tick(); rst_t = 1'b1; bus.dm_req_t = 1'b0;
        tick(); #1;
        chk("rs_mem_en",   bus.mem_en_t,   0);
        chk("rs_mem_addr", bus.mem_addr_t, 0);
        chk("rs_dm_valid", bus.dm_valid_t, 0);
        chk("rs_dm_rdata", bus.dm_rdata_t, 0);
        rst_t = 1'b0;
        tick(); bus.dm_req_t = 1'b1; bus.dm_addr_t = 32'h204; #1;
        chk("rs_no_stale", bus.dm_valid_t, 0);
        tick(); #1;
        chk("rs_new_addr", bus.mem_addr_t, 32'h204);
        tick();
        tick(); bus.dm_req_t = 1'b0; #1;
        chk("rs_new_valid", bus.dm_valid_t, 1);
        chk("rs_new_rdata", bus.dm_rdata_t, 32'hA000_0204);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
